// File: rtl/player_input_unit.sv
// Player input unit: synchronizes and debounces four tile keys and start,
// emits one pulse per accepted tile press, and scores presses against seq.
// Ports: clock, resetn; key_n[3:0], start_n raw buttons (active-low);
//   playerEN, checkEN, ld_current_score, ld_best_score controller strobes;
//   seq[17:0], sequence_counter[3:0] expected tile source;
//   player_input pulse, player_start level, check result, guessed_tile,
//   current_score, best_score.
module player_input_unit #(
  parameter int DEBOUNCE = 250000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [3:0]  key_n,
  input  logic        start_n,
  input  logic        playerEN,
  input  logic        checkEN,
  input  logic        ld_current_score,
  input  logic        ld_best_score,
  input  logic [17:0] seq,
  input  logic [3:0]  sequence_counter,
  output logic        player_input,
  output logic        player_start,
  output logic        check,
  output logic [1:0]  guessed_tile,
  output logic [4:0]  current_score,
  output logic [4:0]  best_score
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_PRESSED  = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [3:0]    keys;
  logic          start_s;
  logic          all_high;
  logic [1:0]    low_idx;
  logic [1:0]    state;
  logic [1:0]    cand;
  logic [CW-1:0] cnt;
  logic [CW-1:0] scnt;
  logic          armed;
  logic [4:0]    score;
  logic [4:0]    idx;
  logic [31:0]   seq_ext;
  logic [1:0]    expected;
  logic          correct;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {start_n, key_n};
      sync2 <= sync1;
    end
  end

  assign keys     = sync2[3:0];
  assign start_s  = sync2[4];
  assign all_high = &keys;

  always_comb begin
    low_idx = 2'd3;
    if (!keys[0])      low_idx = 2'd0;
    else if (!keys[1]) low_idx = 2'd1;
    else if (!keys[2]) low_idx = 2'd2;
  end

  // After reset the unit is disarmed until the keys have been seen high
  // for a full debounce window, so a key held across reset cannot pulse.
  // The reset value of the synchronizers only spans two samples, which
  // is shorter than any sensible window (DEBOUNCE >= 3).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      cand         <= 2'd0;
      cnt          <= '0;
      armed        <= 1'b0;
      guessed_tile <= 2'd0;
      player_input <= 1'b0;
    end else begin
      player_input <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!armed) begin
            if (!all_high) begin
              cnt <= '0;
            end else if (cnt == CMAX) begin
              cnt   <= '0;
              armed <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (!all_high) begin
            cand  <= low_idx;
            cnt   <= '0;
            state <= S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (keys[cand]) begin
            state <= S_IDLE;
          end else if (cnt == CMAX) begin
            cnt <= '0;
            if (playerEN) begin
              guessed_tile <= cand;
              player_input <= 1'b1;
              state        <= S_PRESSED;
            end else begin
              state <= S_RELEASE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_PRESSED: begin
          cnt   <= '0;
          state <= S_RELEASE;
        end
        default: begin
          if (!all_high) begin
            cnt <= '0;
          end else if (cnt == CMAX) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      scnt         <= '0;
      player_start <= 1'b0;
    end else if (~start_s == player_start) begin
      scnt <= '0;
    end else if (scnt == CMAX) begin
      scnt         <= '0;
      player_start <= ~start_s;
    end else begin
      scnt <= scnt + CW'(1);
    end
  end

  // Zero-extended so out-of-range counters index harmlessly.
  assign idx      = {sequence_counter, 1'b0};
  assign seq_ext  = {14'd0, seq};
  assign expected = {seq_ext[idx], seq_ext[idx + 5'd1]};
  assign correct  = (sequence_counter <= 4'd8) &&
                    (guessed_tile == expected);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      check         <= 1'b0;
      score         <= 5'd0;
      current_score <= 5'd0;
      best_score    <= 5'd0;
    end else begin
      if (checkEN) begin
        check <= correct;
        if (!correct)            score <= 5'd0;
        else if (score != 5'd31) score <= score + 5'd1;
      end
      if (ld_current_score) current_score <= score;
      if (ld_best_score && (score > best_score)) best_score <= score;
    end
  end

endmodule

// File: tb/tb_player_input_unit.sv
// Bench for player_input_unit (DEBOUNCE=4): press/score scoreboard.
// Ports: none; drives and monitors the DUT directly.
module tb_player_input_unit;

  logic        clock = 1'b0;
  logic        resetn;
  logic [3:0]  key_n;
  logic        start_n;
  logic        playerEN;
  logic        checkEN;
  logic        ld_current_score;
  logic        ld_best_score;
  logic [17:0] seq;
  logic [3:0]  sequence_counter;
  logic        player_input;
  logic        player_start;
  logic        check;
  logic [1:0]  guessed_tile;
  logic [4:0]  current_score;
  logic [4:0]  best_score;

  player_input_unit #(.DEBOUNCE(4)) dut (
    .clock(clock),
    .resetn(resetn),
    .key_n(key_n),
    .start_n(start_n),
    .playerEN(playerEN),
    .checkEN(checkEN),
    .ld_current_score(ld_current_score),
    .ld_best_score(ld_best_score),
    .seq(seq),
    .sequence_counter(sequence_counter),
    .player_input(player_input),
    .player_start(player_start),
    .check(check),
    .guessed_tile(guessed_tile),
    .current_score(current_score),
    .best_score(best_score)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_pass = 0;
  int npulse = 0;
  int exp_np = 0;

  logic [1:0] tile_q[$];
  logic       chk_q[$];
  logic [1:0] m_tile  = 2'd0;
  logic [4:0] m_score = 5'd0;
  logic [4:0] m_best  = 5'd0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  always @(negedge clock) begin
    if (resetn && player_input) begin
      npulse++;
      if (tile_q.size() == 0) chk("extra_pulse", player_input, 0);
      else chk("pulse_tile", guessed_tile, tile_q.pop_front());
    end
  end

  function automatic logic [1:0] low_of(input logic [3:0] k);
    for (int i = 3; i >= 0; i--) if (!k[i]) low_of = i[1:0];
  endfunction

  function automatic logic [1:0] exp_tile(input logic [17:0] s,
                                          input int c);
    logic [1:0] t;
    t[1] = s[2*c];
    t[0] = s[2*c+1];
    return t;
  endfunction

  task automatic press(input logic [3:0] k, input int hold);
    if (playerEN) begin
      tile_q.push_back(low_of(k));
      m_tile = low_of(k);
      exp_np++;
    end
    key_n = k;
    repeat (hold) @(negedge clock);
    key_n = 4'hF;
    repeat (12) @(negedge clock);
    chk("npulse", npulse, exp_np);
  endtask

  task automatic model_eval();
    logic ok;
    ok = 1'b0;
    if (sequence_counter <= 4'd8)
      ok = (m_tile == exp_tile(seq, int'(sequence_counter)));
    chk_q.push_back(ok);
    if (!ok) m_score = 5'd0;
    else if (m_score != 5'd31) m_score = m_score + 5'd1;
  endtask

  task automatic do_eval();
    model_eval();
    checkEN = 1'b1;
    @(negedge clock);
    checkEN = 1'b0;
    chk("check", check, chk_q.pop_front());
  endtask

  task automatic ld_cur();
    ld_current_score = 1'b1;
    @(negedge clock);
    ld_current_score = 1'b0;
    chk("current_score", current_score, m_score);
  endtask

  task automatic ld_best();
    if (m_score > m_best) m_best = m_score;
    ld_best_score = 1'b1;
    @(negedge clock);
    ld_best_score = 1'b0;
    chk("best_score", best_score, m_best);
  endtask

  task automatic chk_reset_outs();
    chk("rst_player_input", player_input, 0);
    chk("rst_player_start", player_start, 0);
    chk("rst_check", check, 0);
    chk("rst_guessed_tile", guessed_tile, 0);
    chk("rst_current_score", current_score, 0);
    chk("rst_best_score", best_score, 0);
  endtask

  initial begin
    resetn = 1'b0;
    key_n = 4'hF;
    start_n = 1'b1;
    playerEN = 1'b0;
    checkEN = 1'b0;
    ld_current_score = 1'b0;
    ld_best_score = 1'b0;
    seq = 18'b10;
    sequence_counter = 4'd0;
    repeat (3) @(negedge clock);
    chk_reset_outs();
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    playerEN = 1'b1;

    // held key plus a second key: one pulse only
    tile_q.push_back(2'd1);
    m_tile = 2'd1;
    exp_np++;
    key_n = 4'b1101;
    repeat (10) @(negedge clock);
    key_n = 4'b1100;
    repeat (10) @(negedge clock);
    key_n = 4'hF;
    repeat (12) @(negedge clock);
    chk("npulse_held", npulse, exp_np);
    chk("guessed_held", guessed_tile, 1);

    // bounce: no pulse, then a full press still works
    key_n = 4'b1110;
    repeat (2) @(negedge clock);
    key_n = 4'hF;
    repeat (10) @(negedge clock);
    chk("npulse_bounce", npulse, exp_np);
    press(4'b1110, 10);

    // correct then wrong evaluation
    press(4'b1101, 10);
    do_eval();
    ld_cur();
    press(4'b1011, 10);
    do_eval();
    ld_cur();

    // three correct, same-cycle load sees pre-update score
    press(4'b1101, 10);
    do_eval();
    do_eval();
    model_eval();
    chk_q.pop_front();
    ld_current_score = 1'b1;
    ld_best_score = 1'b1;
    checkEN = 1'b1;
    @(negedge clock);
    checkEN = 1'b0;
    ld_current_score = 1'b0;
    ld_best_score = 1'b0;
    chk("cur_pre_update", current_score, 2);
    chk("best_pre_update", best_score, 2);
    m_best = 5'd2;
    ld_cur();
    ld_best();
    press(4'b1011, 10);
    do_eval();
    ld_best();
    chk("best_holds", best_score, 3);

    // out-of-range counter and another sequence slot
    sequence_counter = 4'd9;
    press(4'b1101, 10);
    do_eval();
    seq = 18'b00_00_10_00_00_00_00_00_10;
    sequence_counter = 4'd3;
    press(4'b1011, 10);
    do_eval();
    sequence_counter = 4'd0;
    do_eval();

    // saturation at 31
    press(4'b1101, 10);
    for (int i = 0; i < 33; i++) do_eval();
    ld_cur();
    ld_best();

    // two keys: lowest index; playerEN low needs release
    press(4'b0110, 10);
    playerEN = 1'b0;
    key_n = 4'b0111;
    repeat (12) @(negedge clock);
    playerEN = 1'b1;
    repeat (10) @(negedge clock);
    key_n = 4'hF;
    repeat (12) @(negedge clock);
    chk("npulse_noen", npulse, exp_np);
    press(4'b0111, 10);
    chk("guessed_tile3", guessed_tile, 3);

    // start debounce
    start_n = 1'b0;
    repeat (2) @(negedge clock);
    start_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("start_bounce", player_start, 0);
    start_n = 1'b0;
    repeat (10) @(negedge clock);
    chk("start_on", player_start, 1);
    start_n = 1'b1;
    repeat (10) @(negedge clock);
    chk("start_off", player_start, 0);

    // reset during debounce
    key_n = 4'b1011;
    repeat (4) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk_reset_outs();
    resetn = 1'b1;
    m_score = 5'd0;
    m_best = 5'd0;
    m_tile = 2'd0;
    repeat (20) @(negedge clock);
    chk("npulse_after_rst", npulse, exp_np);
    key_n = 4'hF;
    repeat (12) @(negedge clock);
    press(4'b1011, 10);
    chk("guessed_after_rst", guessed_tile, 2);
    ld_cur();

    chk("sb_empty", tile_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
